// File: rtl/sseg_scan.sv
// Time-multiplexed seven-segment scanner with a double-buffered display value.
// Data is swapped in only at frame boundaries so a frame never mixes old and new digits.
module sseg_scan #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 50000,
  parameter int GUARD       = 500,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            hex,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shval;
  logic [4*DIGITS-1:0] actval;
  logic [DIGITS-1:0]   shdp;
  logic [DIGITS-1:0]   actdp;

  logic                tick;
  logic                boundary;
  logic                lit;
  logic                allz;
  logic [DIGITS-1:0]   supp;
  logic [DIGITS-1:0]   onehot;
  logic [3:0]          nib;
  logic                curdp;
  logic                cursupp;

  // Segment patterns listed g..a, active-low
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b0100111;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick     = (cnt == CW'(CLK_DIV - 1));
    boundary = tick && (idx == IW'(DIGITS - 1));
    lit      = (int'(cnt) >= GUARD) && !blank;
  end

  // A digit is a leading zero when it and every more significant nibble are zero
  always_comb begin
    allz = 1'b1;
    supp = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz    = allz && (actval[4*i +: 4] == 4'h0);
      supp[i] = (LZ_SUPPRESS != 0) && (i > 0) && allz;
    end
  end

  always_comb begin
    nib     = '0;
    curdp   = 1'b0;
    cursupp = 1'b0;
    onehot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx) == i) begin
        nib       = actval[4*i +: 4];
        curdp     = actdp[i];
        cursupp   = supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      shval      <= '0;
      shdp       <= '0;
      actval     <= '0;
      actdp      <= '0;
      pending    <= 1'b0;
      hex        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

      if (load) begin
        shval <= value;
        shdp  <= dp_in;
      end

      // A load on the boundary cycle bypasses the shadow so it is not lost
      if (boundary && (pending || load)) begin
        actval <= load ? value : shval;
        actdp  <= load ? dp_in : shdp;
      end

      if (boundary)
        pending <= 1'b0;
      else if (load)
        pending <= 1'b1;

      frame_done <= boundary;
      an         <= lit ? ~onehot : '1;
      hex        <= (lit && !cursupp) ? decode(nib) : 7'h7F;
      dp         <= lit ? ~curdp : 1'b1;
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
// Directed plus randomized bench for sseg_scan; expected outputs come from a
// cycle-count based model of scan position and the double-buffer rules.
module tb_sseg_scan;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int GUARD   = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  hex;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;

  int          mcycle = 0;
  logic [15:0] mshadow = '0;
  logic [3:0]  mshdp = '0;
  logic [15:0] mact = '0;
  logic [3:0]  mactdp = '0;
  logic        mpend = 1'b0;

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  sseg_scan #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD), .LZ_SUPPRESS(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in),
    .load(load), .blank(blank), .hex(hex), .dp(dp), .an(an),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, mcycle);
    end
  endtask

  // One clock: predict outputs from the state before the edge, then advance the model
  task automatic cycle();
    int         phase;
    int         slot;
    logic       bnd;
    logic       litm;
    logic       sup;
    logic [3:0] n;
    logic [6:0] eh;
    logic       edp;
    logic [3:0] ea;
    logic       efd;
    bnd = 1'b0;
    if (!reset_n) begin
      eh = 7'h7F; edp = 1'b1; ea = 4'hF; efd = 1'b0;
    end else begin
      phase = mcycle % CLK_DIV;
      slot  = (mcycle / CLK_DIV) % DIGITS;
      bnd   = (phase == CLK_DIV - 1) && (slot == DIGITS - 1);
      litm  = (phase >= GUARD) && !blank;
      n     = 4'(mact >> (4 * slot));
      sup   = (slot > 0) && ((mact >> (4 * slot)) == 16'h0);
      ea    = litm ? ~(4'b0001 << slot) : 4'hF;
      eh    = (litm && !sup) ? segtab[n] : 7'h7F;
      edp   = litm ? ~mactdp[slot] : 1'b1;
      efd   = bnd;
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      mcycle = 0; mshadow = '0; mshdp = '0; mact = '0; mactdp = '0; mpend = 1'b0;
    end else begin
      if (bnd && (mpend || load)) begin
        mact   = load ? value : mshadow;
        mactdp = load ? dp_in : mshdp;
      end
      if (load) begin
        mshadow = value;
        mshdp   = dp_in;
      end
      mpend  = bnd ? 1'b0 : (load ? 1'b1 : mpend);
      mcycle = mcycle + 1;
    end
    checkOutput("hex", 32'(hex), 32'(eh));
    checkOutput("dp", 32'(dp), 32'(edp));
    checkOutput("an", 32'(an), 32'(ea));
    checkOutput("frame_done", 32'(frame_done), 32'(efd));
    checkOutput("pending", 32'(pending), 32'(mpend));
  endtask

  task automatic applyStimulus(input logic l, input logic [15:0] v, input logic [3:0] d, input logic b);
    load  = l;
    value = v;
    dp_in = d;
    blank = b;
    cycle();
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, value, dp_in, blank);
  endtask

  // Advance until the model sits at the given slot/phase (reached within one frame)
  task automatic syncTo(input int slot, input int phase);
    for (int i = 0; i < DIGITS * CLK_DIV; i++) begin
      if ((mcycle % CLK_DIV == phase) && ((mcycle / CLK_DIV) % DIGITS == slot)) break;
      idle(1);
    end
  endtask

  initial begin
    logic [15:0] rv;
    $display("[TB] sseg_scan bench start");
    reset_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    idle(5);

    applyStimulus(1'b1, 16'h12AF, 4'b0100, 1'b0);
    idle(3 * DIGITS * CLK_DIV);

    applyStimulus(1'b1, 16'h0050, 4'b0000, 1'b0);
    idle(2 * DIGITS * CLK_DIV);
    applyStimulus(1'b1, 16'h0000, 4'b1000, 1'b0);
    idle(2 * DIGITS * CLK_DIV);

    syncTo(1, 2);
    applyStimulus(1'b1, 16'h1111, 4'b0001, 1'b0);
    idle(3);
    applyStimulus(1'b1, 16'h2222, 4'b0010, 1'b0);
    idle(2 * DIGITS * CLK_DIV);

    syncTo(DIGITS - 1, CLK_DIV - 1);
    applyStimulus(1'b1, 16'hBEEF, 4'b1001, 1'b0);
    idle(2 * DIGITS * CLK_DIV);

    syncTo(2, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, value, dp_in, 1'b1);
    idle(DIGITS * CLK_DIV + 3);

    for (int i = 0; i < 300; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      applyStimulus($urandom_range(0, 7) == 0, rv, 4'($urandom), $urandom_range(0, 15) == 0);
    end
    idle(DIGITS * CLK_DIV);

    syncTo(2, 1);
    reset_n = 1'b0;
    applyStimulus(1'b0, value, dp_in, 1'b0);
    reset_n = 1'b1;
    idle(2 * DIGITS * CLK_DIV);
    applyStimulus(1'b1, 16'hC0D3, 4'b0110, 1'b0);
    idle(2 * DIGITS * CLK_DIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
